// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the restoring divider: the control state encoding and
// the default operand width.
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the difference
// if it did not go negative (otherwise restore), and shift the resulting
// quotient bit into the low end of the working register.
//
// Ports
//   rem_i   [W:0]    partial remainder before the step
//   work_i  [2W-1:0] remaining dividend bits (high) / quotient bits (low)
//   dvs_i   [W-1:0]  divisor magnitude
//   rem_o   [W:0]    partial remainder after the step
//   work_o  [2W-1:0] working register after the step
// -----------------------------------------------------------------------------
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]       rem_i,
    input  logic [2*WIDTH-1:0]   work_i,
    input  logic [WIDTH-1:0]     dvs_i,
    output logic [WIDTH:0]       rem_o,
    output logic [2*WIDTH-1:0]   work_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        // The remainder entering a step is always below the divisor, so the
        // shifted value fits in W+1 bits; the full-width compare decides.
        rem_sh = {rem_i[WIDTH-1:0], work_i[2*WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_i};
        fits   = ({rem_i, work_i[2*WIDTH-1]} >= {2'b00, dvs_i});
        rem_o  = fits ? trial : rem_sh;
        work_o = {work_i[2*WIDTH-2:0], fits};
    end

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor giving a W-bit
// quotient and remainder. One shift-subtract iteration per clock in RUN, then
// a FIX cycle that applies sign correction and the range check.
//
// Build option
//   RESTORING_DIVIDER_SIGNED_EN : operands/results are two's complement
//   (quotient truncates toward zero, remainder takes the dividend's sign).
//   Undefined (default): all unsigned.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        request, sampled in IDLE or DONE only
//   dividend     [2W-1:0] numerator, captured on accepted start
//   divisor      [W-1:0]  denominator, captured on accepted start
//   quotient     [W-1:0]  registered result
//   remainder    [W-1:0]  registered result
//   finished     high in DONE until the next accepted start or reset
//   busy         high in RUN and FIX
//   overflow     quotient not representable in W bits (results forced to 0)
//   div_by_zero  divisor was zero (results forced to 0)
// -----------------------------------------------------------------------------
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 finished,
    output logic                 busy,
    output logic                 overflow,
    output logic                 div_by_zero
);

    localparam int              DW    = 2 * WIDTH;
    localparam int              CNT_W = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] ITER = CNT_W'(DW);

`ifdef RESTORING_DIVIDER_SIGNED_EN
    localparam logic [DW-1:0] Q_POS_LIM = DW'((1 << (WIDTH - 1)) - 1);
    localparam logic [DW-1:0] Q_NEG_LIM = DW'(1 << (WIDTH - 1));

    // Negative quotients may reach one further magnitude than positive ones.
    function automatic logic q_overflow(input logic [DW-1:0] mag, input logic neg);
        return neg ? (mag > Q_NEG_LIM) : (mag > Q_POS_LIM);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        return neg ? -mag : mag;
    endfunction
`else
    function automatic logic q_overflow(input logic [DW-WIDTH-1:0] hi);
        return |hi;
    endfunction
`endif

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     work_q, work_d;
    logic [WIDTH:0]    prem_q, prem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              fin_q, fin_d;
    logic              ovf_q, ovf_d;
    logic              dbz_q, dbz_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
`endif

    logic [DW-1:0]     dvd_mag;
    logic [WIDTH-1:0]  dvs_mag;
    logic [WIDTH:0]    step_rem;
    logic [DW-1:0]     step_work;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    assign dvd_mag = dividend[DW-1]   ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1] ? -divisor  : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (prem_q),
        .work_i (work_q),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .work_o (step_work)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        fin_d   = fin_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fin_d  = 1'b0;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    work_d = dvd_mag;
                    prem_d = '0;
                    dvs_d  = dvs_mag;
                    cnt_d  = ITER;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                    neg_q_d = dividend[DW-1] ^ divisor[WIDTH-1];
                    neg_r_d = dividend[DW-1];
`endif
                    if (divisor == '0) begin
                        // Zero divisor short-circuits straight to DONE.
                        state_d = ST_DONE;
                        dbz_d   = 1'b1;
                        fin_d   = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    work_d = step_work;
                    prem_d = step_rem;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                fin_d   = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                ovf_d = q_overflow(work_q, neg_q_q);
                quo_d = apply_sign(work_q[WIDTH-1:0], neg_q_q);
                rem_d = apply_sign(prem_q[WIDTH-1:0], neg_r_q);
`else
                ovf_d = q_overflow(work_q[DW-1:WIDTH]);
                quo_d = work_q[WIDTH-1:0];
                rem_d = prem_q[WIDTH-1:0];
`endif
                if (ovf_d) begin
                    quo_d = '0;
                    rem_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and visible results: reset clears everything observable, so an
    // aborted operation never exposes partial state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            fin_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            fin_q   <= fin_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working datapath: always reloaded on an accepted start before use.
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        prem_q  <= prem_d;
        dvs_q   <= dvs_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
`endif
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign finished    = fin_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == ST_RUN) || (state_q == ST_FIX);

endmodule

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Table-driven and randomized bench for restoring_divider (WIDTH=4). The
// expected results come from plain integer division; the signed variant is
// selected by RESTORING_DIVIDER_SIGNED_EN, matching the design build.
// Latency is counted in clock edges from the edge that accepts start (that
// edge counts as 1): zero divisor -> 1, normal operation -> 2W+3 = 11.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

    localparam int W       = 4;
    localparam int LAT_RUN = 2 * W + 3;
    localparam int LIMIT   = 40;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [7:0]   dividend;
    logic [3:0]   divisor;
    logic [3:0]   quotient;
    logic [3:0]   remainder;
    logic         finished;
    logic         busy;
    logic         overflow;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [3:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dbz;
    } vec_t;

    vec_t vecs [12];

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .finished    (finished),
        .busy        (busy),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer division from the arithmetic definition.
    function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic ovf, output logic dbz);
        int ia, ib, qi, ri;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        ia = int'($signed(a));
        ib = int'($signed(b));
`else
        ia = int'(a);
        ib = int'(b);
`endif
        q = '0; r = '0; ovf = 1'b0; dbz = 1'b0;
        if (ib == 0) begin
            dbz = 1'b1;
        end else begin
            qi = ia / ib;
            ri = ia % ib;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            ovf = (qi < -8) || (qi > 7);
`else
            ovf = (qi > 15);
`endif
            if (!ovf) begin
                q = 4'(qi);
                r = 4'(ri);
            end
        end
    endfunction

    // Presents one request and waits (bounded) for finished.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          output int cyc, output logic busy_seen,
                          output logic fin0, output logic busy0);
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        cyc       = 0;
        busy_seen = 1'b0;
        fin0      = 1'b0;
        busy0     = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                fin0  = finished;
                busy0 = busy;
            end
            if (busy) busy_seen = 1'b1;
        end while (!finished && cyc < LIMIT);
    endtask

    initial begin
        int         cyc;
        logic       bseen, fin0, busy0;
        logic [3:0] eq, er;
        logic       eovf, edbz;
        logic [7:0] ra;
        logic [3:0] rb;

`ifdef RESTORING_DIVIDER_SIGNED_EN
        vecs[0]  = '{8'h0C, 4'h4, 4'h3, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{8'hF9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};
        vecs[2]  = '{8'h64, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[3]  = '{8'hF8, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{8'hF8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0};
        vecs[5]  = '{8'h07, 4'h1, 4'h7, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{8'h08, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[7]  = '{8'h07, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 4'h2, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[9]  = '{8'h09, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{8'hC0, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[11] = '{8'hC7, 4'h7, 4'h8, 4'hF, 1'b0, 1'b0};
`else
        vecs[0]  = '{8'd12,  4'd4,  4'd3,  4'd0,  1'b0, 1'b0};
        vecs[1]  = '{8'd200, 4'd15, 4'd13, 4'd5,  1'b0, 1'b0};
        vecs[2]  = '{8'd240, 4'd15, 4'd0,  4'd0,  1'b1, 1'b0};
        vecs[3]  = '{8'd7,   4'd2,  4'd3,  4'd1,  1'b0, 1'b0};
        vecs[4]  = '{8'd0,   4'd5,  4'd0,  4'd0,  1'b0, 1'b0};
        vecs[5]  = '{8'd255, 4'd0,  4'd0,  4'd0,  1'b0, 1'b1};
        vecs[6]  = '{8'd100, 4'd3,  4'd0,  4'd0,  1'b1, 1'b0};
        vecs[7]  = '{8'd63,  4'd4,  4'd15, 4'd3,  1'b0, 1'b0};
        vecs[8]  = '{8'd64,  4'd4,  4'd0,  4'd0,  1'b1, 1'b0};
        vecs[9]  = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0};
        vecs[10] = '{8'd5,   4'd9,  4'd0,  4'd5,  1'b0, 1'b0};
        vecs[11] = '{8'd0,   4'd0,  4'd0,  4'd0,  1'b0, 1'b1};
`endif

        // Reset with a zero-divisor start pending: reset must win.
        reset_n  = 1'b0;
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.quotient",  int'(quotient),    0);
        check("rst.remainder", int'(remainder),   0);
        check("rst.finished",  int'(finished),    0);
        check("rst.busy",      int'(busy),        0);
        check("rst.overflow",  int'(overflow),    0);
        check("rst.dbz",       int'(div_by_zero), 0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, cyc, bseen, fin0, busy0);
            check($sformatf("vec%0d.latency", i), cyc, vecs[i].dbz ? 1 : LAT_RUN);
            check($sformatf("vec%0d.quotient", i), int'(quotient), int'(vecs[i].q));
            check($sformatf("vec%0d.remainder", i), int'(remainder), int'(vecs[i].r));
            check($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].ovf));
            check($sformatf("vec%0d.dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
            check($sformatf("vec%0d.busy_seen", i), int'(bseen), vecs[i].dbz ? 0 : 1);
            if (!vecs[i].dbz) begin
                check($sformatf("vec%0d.fin_after_accept", i), int'(fin0), 0);
                check($sformatf("vec%0d.busy_after_accept", i), int'(busy0), 1);
            end
        end

        // Start pulse and operand changes during RUN are ignored.
        dividend = 8'd12;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b1;
        dividend = 8'd7;
        divisor  = 4'd1;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        check("ignore.busy", int'(busy), 1);
        while (!finished && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ignore.latency",   cyc, LAT_RUN);
        check("ignore.quotient",  int'(quotient), 3);
        check("ignore.remainder", int'(remainder), 0);
        check("ignore.overflow",  int'(overflow), 0);

        // Reset on the third RUN edge aborts with nothing visible.
        dividend = 8'd12;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort.quotient",  int'(quotient),    0);
        check("abort.remainder", int'(remainder),   0);
        check("abort.finished",  int'(finished),    0);
        check("abort.busy",      int'(busy),        0);
        check("abort.overflow",  int'(overflow),    0);
        check("abort.dbz",       int'(div_by_zero), 0);
        repeat (12) @(posedge clk);
        #1;
        check("abort.stays_idle_fin",  int'(finished), 0);
        check("abort.stays_idle_busy", int'(busy),     0);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 150; n++) begin
            rb = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1)
                ra = 8'($urandom_range(0, 255));
            else
                ra = 8'($urandom_range(0, 63));
            model(ra, rb, eq, er, eovf, edbz);
            run_op(ra, rb, cyc, bseen, fin0, busy0);
            check($sformatf("rnd%0d.latency(%0d/%0d)", n, ra, rb), cyc, edbz ? 1 : LAT_RUN);
            check($sformatf("rnd%0d.quotient(%0d/%0d)", n, ra, rb), int'(quotient), int'(eq));
            check($sformatf("rnd%0d.remainder(%0d/%0d)", n, ra, rb), int'(remainder), int'(er));
            check($sformatf("rnd%0d.overflow(%0d/%0d)", n, ra, rb), int'(overflow), int'(eovf));
            check($sformatf("rnd%0d.dbz(%0d/%0d)", n, ra, rb), int'(div_by_zero), int'(edbz));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width W; dividend is 2W bits, divisor, quotient and remainder are W bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port: dividend  input  2W  numerator, captured when start is accepted.
REQ-006 SHALL have port: divisor  input  W  denominator, captured when start is accepted.
REQ-007 SHALL have port: quotient  output  W  registered result.
REQ-008 SHALL have port: remainder  output  W  registered result.
REQ-009 SHALL have port: finished  output  1  high in DONE; held until next accepted start or reset.
REQ-010 SHALL have port: busy  output  1  high in RUN and FIX.
REQ-011 SHALL have port: overflow  output  1  quotient not representable in W bits.
REQ-012 SHALL have port: div_by_zero  output  1  divisor was zero.

Function
REQ-013 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-014 Transitions SHALL be: IDLE/DONE + start -> RUN (or DONE if divisor==0); RUN -> FIX after 2W iterations; FIX -> DONE.
REQ-015 On accepting start, the block SHALL capture operand magnitudes and signs, clear finished/overflow/div_by_zero, and load the iteration counter with 2W.
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle over a 2W-bit unsigned quotient and a (W+1)-bit partial remainder.
REQ-017 FIX SHALL apply sign correction: quotient truncates toward zero, remainder takes the dividend's sign; outputs are registered and finished is set on entering DONE.
REQ-018 Latency SHALL be: start accepted at edge E0, finished=1 after edge E(2W+2), which is edge E10 for W=4.
REQ-019 When the corrected quotient is outside the W-bit range, the block SHALL drive overflow=1 and quotient=remainder=0.
REQ-020 When divisor==0, the block SHALL go IDLE -> DONE in one edge with div_by_zero=1, quotient=remainder=0 and overflow=0.
REQ-021 start SHALL be ignored while busy=1; operand changes during RUN SHALL have no effect.
REQ-022 start in DONE SHALL begin a new operation on that edge, and finished SHALL fall on the same edge.

Reset
REQ-023 While reset_n=0 at a clk edge, the block SHALL enter IDLE with quotient, remainder, finished, busy, overflow and div_by_zero all 0; reset dominates start.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no partial result visible.

Configuration
REQ-025 With RESTORING_DIVIDER_SIGNED_EN defined, all operands and results SHALL be two's complement and the quotient range SHALL be [-2^(W-1), 2^(W-1)-1].
REQ-026 Without RESTORING_DIVIDER_SIGNED_EN, all operands and results SHALL be unsigned, the FIX stage SHALL skip sign correction, and overflow SHALL be set when quotient >= 2^W; latency is unchanged.

Structure
REQ-027 Shared package divider_pkg SHALL hold the state enum type and the default-width constant.
REQ-028 Sub-module div_step SHALL be the combinational single iteration (shift, trial subtract, restore, quotient bit), instantiated once.

Verification (W=4, signed unless noted)
REQ-029 Case 1: dividend=8'd12, divisor=4'd4 -> quotient=4'b0011, remainder=0, finished exactly 10 edges after acceptance (inverse of 4*3).
REQ-030 Case 2: dividend=8'hF9 (-7), divisor=4'd2 -> quotient=4'b1101 (-3), remainder=4'b1111 (-1), overflow=0.
REQ-031 Case 3: dividend=8'd100, divisor=4'd3 -> overflow=1, quotient=0, remainder=0; dividend=8'hF8, divisor=4'hF (-8/-1) -> overflow=1.
REQ-032 Case 4: divisor=0 -> div_by_zero=1 and finished=1 one edge after acceptance; busy never asserts.
REQ-033 Case 5: reset_n=0 on the 3rd RUN edge -> next state IDLE, all outputs 0; a start pulse during RUN -> ignored, result unchanged.
REQ-034 Case 6 (macro undefined): dividend=8'd200, divisor=4'd15 -> quotient=4'd13, remainder=4'd5; dividend=8'd240, divisor=4'd15 -> overflow=1.
